// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths for the skid-buffered pipeline stage.
package pipe_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int CTRL_W_DEF = 8;
    localparam int LEVEL_W    = 2;
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one instruction holding register (valid + ctrl + data) with load/clear.
module pipe_slot #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              ld_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);
    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;

    // clear beats load so a flush always wins over a same-cycle transfer
    always_comb begin
        valid_d = clr_i ? 1'b0 : (ld_i ? 1'b1 : valid_q);
        ctrl_d  = clr_i ? '0 : (ld_i ? ctrl_i : ctrl_q);
        data_d  = clr_i ? '0 : (ld_i ? data_i : data_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: pipeline register with a skid slot so in_ready_o is fully registered.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [CTRL_W-1:0]  in_ctrl_i,
    input  logic [DATA_W-1:0]  in_data_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [CTRL_W-1:0]  out_ctrl_o,
    output logic [DATA_W-1:0]  out_data_o,
    input  logic               flush_i,
    output logic [LEVEL_W-1:0] level_o
);
    logic              main_v, skid_v, in_fire, out_fire;
    logic              main_ld, main_clr, skid_ld, skid_clr;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_src;
    logic [DATA_W-1:0] main_data, skid_data, main_data_src;

    assign in_ready_o = ~skid_v & ~rst_i;
    assign in_fire    = in_valid_i & in_ready_o;
    assign out_fire   = main_v & out_ready_i;

    // in_fire implies an empty skid, so the skid source only matters when refilling main from it
    always_comb begin
        main_ld       = (skid_v & out_fire) | (in_fire & (~main_v | out_fire));
        main_clr      = flush_i | (out_fire & ~skid_v & ~in_fire);
        main_ctrl_src = skid_v ? skid_ctrl : in_ctrl_i;
        main_data_src = skid_v ? skid_data : in_data_i;
        skid_ld       = in_fire & main_v & ~out_fire;
        skid_clr      = flush_i | (skid_v & out_fire);
    end

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (main_clr),
        .ld_i    (main_ld),
        .ctrl_i  (main_ctrl_src),
        .data_i  (main_data_src),
        .valid_o (main_v),
        .ctrl_o  (main_ctrl),
        .data_o  (main_data)
    );

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (skid_clr),
        .ld_i    (skid_ld),
        .ctrl_i  (in_ctrl_i),
        .data_i  (in_data_i),
        .valid_o (skid_v),
        .ctrl_o  (skid_ctrl),
        .data_o  (skid_data)
    );

    assign out_valid_o = main_v;
    assign out_data_o  = main_data;
    assign out_ctrl_o  = main_v ? main_ctrl : '0;
    assign level_o     = LEVEL_W'(main_v) + LEVEL_W'(skid_v);
endmodule
